// File: rtl/width_16to8_pkg.sv
// Shared types and byte-ordering helpers for the 16-to-8 serializer.
// The state encoding and byte split are kept here so the packer side can reuse them.
package width_16to8_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    function automatic logic [BYTE_W-1:0] first_byte(input logic [WORD_W-1:0] w,
                                                     input logic             msb_first);
        return msb_first ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [BYTE_W-1:0] second_byte(input logic [WORD_W-1:0] w,
                                                      input logic             msb_first);
        return msb_first ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/width_16to8_if.sv
// Word-in / byte-out stream bundle for the serializer.
// slave is the serializer's view; master is the view of whatever drives and sinks it.
interface width_16to8_if;
    import width_16to8_pkg::*;

    logic              valid_in;
    logic              ready_in;
    logic [WORD_W-1:0] data_in;
    logic              last_in;
    logic              valid_out;
    logic              ready_out;
    logic [BYTE_W-1:0] data_out;
    logic              last_out;

    modport slave (
        input  valid_in,
        input  data_in,
        input  last_in,
        input  ready_out,
        output ready_in,
        output valid_out,
        output data_out,
        output last_out
    );

    modport master (
        output valid_in,
        output data_in,
        output last_in,
        output ready_out,
        input  ready_in,
        input  valid_out,
        input  data_out,
        input  last_out
    );

endinterface

// File: rtl/width_16to8_skid.sv
// One-word pending buffer (16-bit word + last flag) holding a word accepted
// while the output stage is still busy with the previous one.
module width_16to8_skid
    import width_16to8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              take,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_last,
    output logic [WORD_W-1:0] pend_data,
    output logic              pend_last,
    output logic              pend_valid
);

    // load only happens while empty and take only while full, so they never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_last  <= 1'b0;
        end else if (load) begin
            pend_valid <= 1'b1;
            pend_data  <= load_data;
            pend_last  <= load_last;
        end else if (take) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/width_16to8.sv
// Serializer: accepts 16-bit words and emits them as two registered bytes,
// with a one-word pending buffer so an always-ready sink sees a byte every cycle.
module width_16to8
    import width_16to8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
)(
    input  logic         clk,
    input  logic         rst,
    width_16to8_if.slave bus
);

    state_t            state_q, state_nx;
    logic [BYTE_W-1:0] data_q, data_nx;
    logic              last_q, last_nx;
    logic              valid_q, valid_nx;
    logic [BYTE_W-1:0] cur_lo, cur_lo_nx;
    logic              cur_last, cur_last_nx;

    logic [WORD_W-1:0] pend_data;
    logic              pend_last;
    logic              pend_valid;
    logic              pend_load;
    logic              pend_take;

    logic              fire_in;
    logic              fire_out;
    logic              ld_en;
    logic [WORD_W-1:0] ld_word;
    logic              ld_last;

    assign bus.ready_in  = ~rst & ~pend_valid;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.last_out  = last_q;

    assign fire_in  = bus.valid_in & bus.ready_in;
    assign fire_out = valid_q & bus.ready_out;

    // A held pending word always goes out before anything newly offered
    assign ld_word = pend_valid ? pend_data : bus.data_in;
    assign ld_last = pend_valid ? pend_last : bus.last_in;

    width_16to8_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_load),
        .take       (pend_take),
        .load_data  (bus.data_in),
        .load_last  (bus.last_in),
        .pend_data  (pend_data),
        .pend_last  (pend_last),
        .pend_valid (pend_valid)
    );

    always_comb begin
        state_nx    = state_q;
        data_nx     = data_q;
        last_nx     = last_q;
        valid_nx    = valid_q;
        cur_lo_nx   = cur_lo;
        cur_last_nx = cur_last;
        pend_load   = 1'b0;
        pend_take   = 1'b0;
        ld_en       = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (fire_in) ld_en = 1'b1;
            end
            ST_FIRST: begin
                if (fire_out) begin
                    data_nx  = cur_lo;
                    last_nx  = cur_last;
                    state_nx = ST_SECOND;
                end
                if (fire_in) pend_load = 1'b1;
            end
            ST_SECOND: begin
                if (fire_out) begin
                    if (pend_valid) begin
                        ld_en     = 1'b1;
                        pend_take = 1'b1;
                    end else if (fire_in) begin
                        ld_en = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                        last_nx  = 1'b0;
                        state_nx = ST_EMPTY;
                    end
                end else if (fire_in) begin
                    pend_load = 1'b1;
                end
            end
            default: begin
                valid_nx = 1'b0;
                last_nx  = 1'b0;
                state_nx = ST_EMPTY;
            end
        endcase

        // Loading a word presents its first byte, which never carries last
        if (ld_en) begin
            data_nx     = first_byte(ld_word, MSB_FIRST);
            cur_lo_nx   = second_byte(ld_word, MSB_FIRST);
            cur_last_nx = ld_last;
            valid_nx    = 1'b1;
            last_nx     = 1'b0;
            state_nx    = ST_FIRST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            cur_lo   <= '0;
            cur_last <= 1'b0;
        end else begin
            state_q  <= state_nx;
            data_q   <= data_nx;
            last_q   <= last_nx;
            valid_q  <= valid_nx;
            cur_lo   <= cur_lo_nx;
            cur_last <= cur_last_nx;
        end
    end

endmodule
